res_st_alloc: RTL and testbench

RES_ST_ALLOC -- requirements
Module: res_st_alloc

---
 rtl/qu_common_pkg.sv | 6 +
 rtl/qu_uop_pkg.sv | 12 +
 rtl/prio_enc.sv | 23 ++
 rtl/res_st_alloc.sv | 85 ++++++++
 tb/tb_res_st_alloc.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qu_common_pkg.sv
// Constants shared across the queue/dispatch blocks.
package qu_common;

    localparam int unsigned RES_ST_DEPTH_DEF = 32;

endpackage

// File: rtl/qu_uop_pkg.sv
// Micro-op and reservation-station cell layouts.
package qu_uop;

    typedef struct packed {
        logic        busy;
        logic [12:0] op;
        logic [5:0]  dst;
        logic [5:0]  src1;
        logic [5:0]  src2;
    } res_st_cell_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit of req.
module prio_enc #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]         req,
    output logic [$clog2(W)-1:0] idx,
    output logic                 found
);

    localparam int unsigned IW = $clog2(W);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/res_st_alloc.sv
// Reservation-station entry allocator: hands out the lowest free entry per
// accepted uop, tracks occupancy, and frees entries on release or flush.
module res_st_alloc
    import qu_common::*;
    import qu_uop::*;
#(
    parameter int unsigned RES_ST_DEPTH = RES_ST_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  res_st_cell_t                  in_cell,
    output logic                          wr_en,
    output logic [$clog2(RES_ST_DEPTH)-1:0] wr_addr,
    output res_st_cell_t                  wr_in,
    input  logic                          rel_en,
    input  logic [$clog2(RES_ST_DEPTH)-1:0] rel_addr,
    input  logic                          flush,
    output logic [$clog2(RES_ST_DEPTH):0] free_cnt,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(RES_ST_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RES_ST_DEPTH);

    logic [RES_ST_DEPTH-1:0] alloc_vec;
    logic [RES_ST_DEPTH-1:0] free_vec;
    logic [RES_ST_DEPTH-1:0] vec_next;
    logic [AW-1:0]           sel_idx;
    logic                    sel_found;
    logic                    accept;
    logic                    rel_hit;
    logic [CW-1:0]           cnt_next;
    res_st_cell_t            cell_next;

    assign free_vec = ~alloc_vec;

    prio_enc #(.W(RES_ST_DEPTH)) u_prio_enc (
        .req   (free_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign full     = (free_cnt == '0);
    assign empty    = (free_cnt == DEPTH_CNT);
    assign in_ready = ~full;
    assign accept   = in_valid & in_ready & sel_found;
    // A release of an already-free entry is a no-op, so it must not bump the count.
    assign rel_hit  = rel_en & alloc_vec[rel_addr];

    always_comb begin
        vec_next = alloc_vec;
        if (rel_hit) vec_next[rel_addr] = 1'b0;
        if (accept)  vec_next[sel_idx]  = 1'b1;
        cnt_next       = free_cnt + CW'(rel_hit) - CW'(accept);
        cell_next      = in_cell;
        cell_next.busy = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_vec <= '0;
            free_cnt  <= DEPTH_CNT;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_in     <= '0;
        end else if (flush) begin
            alloc_vec <= '0;
            free_cnt  <= DEPTH_CNT;
            wr_en     <= 1'b0;
        end else begin
            alloc_vec <= vec_next;
            free_cnt  <= cnt_next;
            wr_en     <= accept;
            if (accept) begin
                wr_addr <= sel_idx;
                wr_in   <= cell_next;
            end
        end
    end

endmodule

// File: tb/tb_res_st_alloc.sv
// Randomized + directed bench for res_st_alloc against an occupancy-array model.
module tb_res_st_alloc;
    import qu_common::*;
    import qu_uop::*;

    localparam int DEPTH = RES_ST_DEPTH_DEF;
    localparam int AW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    res_st_cell_t      in_cell;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    res_st_cell_t      wr_in;
    logic              rel_en;
    logic [AW-1:0]     rel_addr;
    logic              flush;
    logic [AW:0]       free_cnt;
    logic              full;
    logic              empty;

    res_st_alloc #(.RES_ST_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cell  (in_cell),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_in    (wr_in),
        .rel_en   (rel_en),
        .rel_addr (rel_addr),
        .flush    (flush),
        .free_cnt (free_cnt),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: which entries are occupied, and what the last write should look like.
    bit           occ [DEPTH];
    logic         exp_wr_en;
    logic [AW-1:0] exp_wr_addr;
    res_st_cell_t exp_wr_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_free();
        int n = 0;
        foreach (occ[i]) if (!occ[i]) n++;
        return n;
    endfunction

    function automatic int model_lowest();
        for (int i = 0; i < DEPTH; i++) if (!occ[i]) return i;
        return -1;
    endfunction

    function automatic res_st_cell_t rand_cell(input logic [12:0] op);
        res_st_cell_t c;
        c      = res_st_cell_t'($urandom);
        c.op   = op;
        return c;
    endfunction

    task automatic model_reset();
        foreach (occ[i]) occ[i] = 1'b0;
        exp_wr_en   = 1'b0;
        exp_wr_addr = '0;
        exp_wr_in   = '0;
    endtask

    task automatic check_outputs();
        int n;
        n = model_free();
        check("free_cnt", 64'(free_cnt), 64'(n));
        check("full",     64'(full),     64'(n == 0));
        check("empty",    64'(empty),    64'(n == DEPTH));
        check("in_ready", 64'(in_ready), 64'(n != 0));
        check("wr_en",    64'(wr_en),    64'(exp_wr_en));
        check("wr_addr",  64'(wr_addr),  64'(exp_wr_addr));
        check("wr_in",    64'(wr_in),    64'(exp_wr_in));
    endtask

    // Apply one clock edge with the currently driven inputs, advance the model, compare.
    task automatic step();
        int  sel;
        bit  acc;
        acc = in_valid && (model_free() != 0);
        sel = model_lowest();
        if (flush) begin
            foreach (occ[i]) occ[i] = 1'b0;
            exp_wr_en = 1'b0;
        end else begin
            if (rel_en && occ[rel_addr]) occ[rel_addr] = 1'b0;
            if (acc) begin
                occ[sel]       = 1'b1;
                exp_wr_en      = 1'b1;
                exp_wr_addr    = AW'(sel);
                exp_wr_in      = in_cell;
                exp_wr_in.busy = 1'b1;
            end else begin
                exp_wr_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        rel_en   = 1'b0;
        flush    = 1'b0;
    endtask

    // Asynchronous reset: outputs must drop immediately, and stay put across an edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        in_cell  = '0;
        rel_addr = '0;
        idle();
        #2;
        do_reset();
        check("rst_free_cnt", 64'(free_cnt), 64'(32));
        check("rst_empty",    64'(empty),    64'(1));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_wr_en",    64'(wr_en),    64'(0));

        // Sequential fill
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_cell  = rand_cell(13'h1E0F);
            step();
            check("fill_addr", 64'(wr_addr), 64'(i));
            check("fill_busy", 64'(wr_in.busy), 64'(1));
            check("fill_op",   64'(wr_in.op), 64'(13'h1E0F));
        end
        check("fill_full",     64'(full),     64'(1));
        check("fill_in_ready", 64'(in_ready), 64'(0));
        in_cell = rand_cell(13'h1E0F);
        step();
        check("held_wr_en", 64'(wr_en), 64'(0));

        // Release while full
        idle();
        rel_en   = 1'b1;
        rel_addr = AW'(5);
        step();
        check("rel5_in_ready", 64'(in_ready), 64'(1));
        rel_en   = 1'b0;
        in_valid = 1'b1;
        in_cell  = rand_cell(13'h0042);
        step();
        check("rel5_addr", 64'(wr_addr), 64'(5));
        check("rel5_free", 64'(free_cnt), 64'(0));

        // Simultaneous alloc and release with 0..3 occupied
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_cell  = rand_cell(13'(i));
            step();
        end
        rel_en   = 1'b1;
        rel_addr = AW'(1);
        in_cell  = rand_cell(13'h0100);
        step();
        check("sim_addr", 64'(wr_addr), 64'(4));
        check("sim_free", 64'(free_cnt), 64'(28));
        rel_en  = 1'b0;
        in_cell = rand_cell(13'h0101);
        step();
        check("sim_next_addr", 64'(wr_addr), 64'(1));

        // Double release of a free entry
        idle();
        rel_en   = 1'b1;
        rel_addr = AW'(7);
        step();
        check("dbl_rel_1", 64'(free_cnt), 64'(27));
        step();
        check("dbl_rel_2", 64'(free_cnt), 64'(27));

        // Flush beats same-cycle accept and release
        in_valid = 1'b1;
        rel_addr = AW'(0);
        flush    = 1'b1;
        in_cell  = rand_cell(13'h0777);
        step();
        check("flush_wr_en", 64'(wr_en), 64'(0));
        check("flush_free",  64'(free_cnt), 64'(32));

        // Reset mid-fill, then allocation restarts at 0
        idle();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_cell  = rand_cell(13'(100 + i));
            step();
        end
        do_reset();
        check("midrst_wr_en", 64'(wr_en), 64'(0));
        in_valid = 1'b1;
        in_cell  = rand_cell(13'h0ABC);
        step();
        check("midrst_addr", 64'(wr_addr), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_cell  = res_st_cell_t'($urandom);
            rel_en   = ($urandom_range(0, 1) == 1);
            rel_addr = AW'($urandom_range(0, DEPTH - 1));
            flush    = ($urandom_range(0, 99) == 0);
            step();
            if (i == 750) begin
                idle();
                do_reset();
            end
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
